// File: rtl/fp32_pkg.sv
// Shared fp32 definitions for the softmax backward datapath: field layout,
// special constants, packed-vector lane selection and the controller states.
package fp32_pkg;

  localparam int N_LANES = 4;
  localparam int FP_W    = 32;
  localparam int VEC_W   = N_LANES * FP_W;
  localparam int LANE_W  = $clog2(N_LANES);
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;

  localparam logic [FP_W-1:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP32_ONE  = 32'h3F80_0000;
  localparam logic [FP_W-1:0] FP32_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DOT,
    ST_SCALE,
    ST_DONE
  } state_e;

  // Lane 0 lives in the most significant slice of the packed vector.
  function automatic logic [FP_W-1:0] lane_sel(input logic [VEC_W-1:0] v,
                                               input logic [LANE_W-1:0] k);
    return v[VEC_W-1-FP_W*int'(k) -: FP_W];
  endfunction

endpackage

// File: rtl/fp32_mac.sv
// Combinational unfused multiply-add: rne(rne(a*b) + c), flush-to-zero,
// saturating to Inf, any NaN giving the canonical quiet NaN.
module fp32_mac
  import fp32_pkg::*;
(
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  input  logic [FP_W-1:0] c_i,
  output logic [FP_W-1:0] r_o
);

  function automatic logic is_zero(input logic [FP_W-1:0] x);
    return x[FP_W-2 -: EXP_W] == '0;
  endfunction

  function automatic logic is_inf(input logic [FP_W-1:0] x);
    return (x[FP_W-2 -: EXP_W] == '1) && (x[MAN_W-1:0] == '0);
  endfunction

  function automatic logic is_nan(input logic [FP_W-1:0] x);
    return (x[FP_W-2 -: EXP_W] == '1) && (x[MAN_W-1:0] != '0);
  endfunction

  function automatic logic [FP_W-1:0] fp_mul(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic              s;
    logic [47:0]       mp;
    logic [23:0]       m;
    logic [24:0]       mr;
    logic              g, st;
    logic signed [9:0] e;
    logic [FP_W-1:0]   r;
    s  = a[31] ^ b[31];
    mp = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'(BIAS);
    if (mp[47]) begin
      m = mp[47:24]; g = mp[23]; st = |mp[22:0]; e = e + 10'sd1;
    end else begin
      m = mp[46:23]; g = mp[22]; st = |mp[21:0];
    end
    mr = {1'b0, m} + 25'(g & (st | m[0]));
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (is_nan(a) || is_nan(b))                                     r = FP32_QNAN;
    else if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) r = FP32_QNAN;
    else if (is_inf(a) || is_inf(b))                                r = {s, 8'hFF, 23'h0};
    else if (is_zero(a) || is_zero(b))                              r = {s, 31'h0};
    else if (e >= 10'sd255)                                         r = {s, 8'hFF, 23'h0};
    else if (e <= 10'sd0)                                           r = {s, 31'h0};
    else                                                            r = {s, e[7:0], mr[22:0]};
    return r;
  endfunction

  function automatic logic [FP_W-1:0] fp_add(input logic [FP_W-1:0] p, input logic [FP_W-1:0] c);
    logic [FP_W-1:0]   big, sml, r;
    logic [7:0]        d;
    logic [26:0]       mb, ms, sh;
    logic              st, g, st2;
    logic [27:0]       sum, n;
    logic [4:0]        msb, lz;
    logic signed [9:0] e;
    logic [24:0]       mr;
    if (p[30:0] >= c[30:0]) begin big = p; sml = c; end
    else                    begin big = c; sml = p; end
    d  = big[30:23] - sml[30:23];
    mb = {1'b1, big[22:0], 3'b000};
    ms = {1'b1, sml[22:0], 3'b000};
    if (d > 8'd26) begin
      sh = 27'd0; st = 1'b1;
    end else begin
      sh = ms >> d; st = |(ms & ~(27'h7FF_FFFF << d));
    end
    sh[0] = sh[0] | st;
    if (big[31] == sml[31]) sum = {1'b0, mb} + {1'b0, sh};
    else                    sum = {1'b0, mb} - {1'b0, sh};
    msb = 5'd0;
    for (int i = 0; i < 28; i++) if (sum[i]) msb = 5'(i);
    e  = $signed({2'b00, big[30:23]});
    lz = 5'd0;
    if (msb == 5'd27) begin
      n = {1'b0, sum[27:2], sum[1] | sum[0]};
      e = e + 10'sd1;
    end else begin
      lz = 5'd26 - msb;
      n  = sum << lz;
      e  = e - $signed({5'b00000, lz});
    end
    g   = n[2];
    st2 = n[1] | n[0];
    mr  = {1'b0, n[26:3]} + 25'(g & (st2 | n[3]));
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (is_nan(p) || is_nan(c))                               r = FP32_QNAN;
    else if (is_inf(p) && is_inf(c) && (p[31] != c[31]))      r = FP32_QNAN;
    else if (is_inf(p))                                       r = p;
    else if (is_inf(c))                                       r = c;
    // A zero addend passes the rounded product through unchanged, sign included.
    else if (is_zero(c))                                      r = p;
    else if (is_zero(p))                                      r = c;
    else if (sum == '0)                                       r = FP32_ZERO;
    else if (e >= 10'sd255)                                   r = {big[31], 8'hFF, 23'h0};
    else if (e <= 10'sd0)                                     r = {big[31], 31'h0};
    else                                                      r = {big[31], e[7:0], mr[22:0]};
    return r;
  endfunction

  assign r_o = fp_add(fp_mul(a_i, b_i), c_i);

endmodule

// File: rtl/softmax_backward.sv
// Softmax backward pass dx_i = y_i*(g_i - sum_k y_k*g_k) on packed 4-lane fp32
// vectors, sequenced over one shared multiply-add unit.
module softmax_backward
  import fp32_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] y,
  input  logic [VEC_W-1:0] grad,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] dx,
  output logic             busy
);

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   k_q, k_d;
  logic                phase_q, phase_d;  // 0: t = g_k - s, 1: dx_k = y_k * t
  logic [VEC_W-1:0]    y_q, g_q;
  logic [FP_W-1:0]     acc_q, t_q;
  logic [FP_W-1:0]     dx_q [N_LANES];
  logic [FP_W-1:0]     mac_a, mac_b, mac_c, mac_r;
  logic                accept;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);

  assign accept = (state_q == ST_IDLE) && in_valid;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    phase_d = phase_q;
    mac_a   = lane_sel(y_q, k_q);
    mac_b   = lane_sel(g_q, k_q);
    mac_c   = acc_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) begin
        state_d = ST_DOT;
        k_d     = '0;
      end
      ST_DOT: begin
        k_d = k_q + 1'b1;
        if (k_q == LAST_LANE) begin
          state_d = ST_SCALE;
          phase_d = 1'b0;
        end
      end
      ST_SCALE: begin
        if (!phase_q) begin
          mac_a   = {~acc_q[FP_W-1], acc_q[FP_W-2:0]};
          mac_b   = FP32_ONE;
          mac_c   = lane_sel(g_q, k_q);
          phase_d = 1'b1;
        end else begin
          mac_b   = t_q;
          mac_c   = FP32_ZERO;
          phase_d = 1'b0;
          k_d     = k_q + 1'b1;
          if (k_q == LAST_LANE) state_d = ST_DONE;
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  fp32_mac u_mac (
    .a_i (mac_a),
    .b_i (mac_b),
    .c_i (mac_c),
    .r_o (mac_r)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      phase_q <= 1'b0;
      acc_q   <= FP32_ZERO;
      for (int i = 0; i < N_LANES; i++) dx_q[i] <= FP32_ZERO;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      phase_q <= phase_d;
      if (accept)                  acc_q     <= FP32_ZERO;
      else if (state_q == ST_DOT)  acc_q     <= mac_r;
      if (state_q == ST_SCALE && phase_q) dx_q[k_q] <= mac_r;
    end
  end

  // NOTE: operand and temporary registers carry no reset; they are always written before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      y_q <= y;
      g_q <= grad;
    end
    if (state_q == ST_SCALE && !phase_q) t_q <= mac_r;
  end

  always_comb begin
    dx = '0;
    for (int i = 0; i < N_LANES; i++) dx[VEC_W-1-FP_W*i -: FP_W] = dx_q[i];
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_softmax_backward.sv
// Directed scoreboard bench for softmax_backward: the driver queues expected dx
// on each accept, an independent monitor checks every output handshake.
module tb_softmax_backward;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] y, grad, dx;

  softmax_backward dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .grad      (grad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dx        (dx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [127:0] dx;
    int           acc_edge;
    bit           chk_lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_bad = 0;
  int   hs_edge = -1;
  int   rise_edge = -1;
  logic ov_prev = 1'b0;

  localparam logic [127:0] Y1  = {4{32'h3E800000}};
  localparam logic [127:0] G1  = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  localparam logic [127:0] D1  = {32'hBEC00000, 32'hBE000000, 32'h3E000000, 32'h3EC00000};
  localparam logic [127:0] Y2  = {32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3E000000};
  localparam logic [127:0] G2  = {4{32'h3F800000}};
  localparam logic [127:0] D2  = 128'h0;
  localparam logic [127:0] Y3  = {32'h3F800000, 32'h0, 32'h0, 32'h0};
  localparam logic [127:0] G3  = {32'h40000000, 32'h40A00000, 32'hBF800000, 32'h40400000};
  localparam logic [127:0] D3  = {32'h00000000, 32'h00000000, 32'h80000000, 32'h00000000};
  localparam logic [127:0] GN  = {32'h3F800000, 32'h7FC00000, 32'h40400000, 32'h40800000};
  localparam logic [127:0] DN  = {4{32'h7FC00000}};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge; a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) rise_edge = cyc + 1;
    ov_prev = out_valid;
    if (out_valid && out_ready) begin
      hs_edge = cyc + 1;
      if (sb_q.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL unexpected_output: got dx=%h with no transaction pending", dx);
      end else begin
        mon_e = sb_q.pop_front();
        check("dx", dx, mon_e.dx);
        if (mon_e.chk_lat) check("latency", 128'(rise_edge - mon_e.acc_edge), 128'd13);
      end
    end
  end

  // Drives a vector pair, waits for the accept edge, and queues the expected result.
  task automatic send(input logic [127:0] yy, input logic [127:0] gg, input logic [127:0] exp,
                      input bit expect_out, input bit keep, output int acc_edge);
    int budget = 0;
    y        = yy;
    grad     = gg;
    in_valid = 1'b1;
    acc_edge = -1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      budget++;
      if (budget > 100) begin
        check("accept_timeout", 128'(in_ready), 128'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    acc_edge = cyc;
    if (expect_out) sb_q.push_back('{exp, acc_edge, 1'b1});
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0 && in_ready) return;
    end
    check("idle_timeout", 128'(sb_q.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2;
    bit seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    y         = '0;
    grad      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  128'(in_ready),  128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_dx",        dx,              128'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Case 1: basic vector, latency checked by the monitor.
    send(Y1, G1, D1, 1'b1, 1'b0, a1);
    @(negedge clk);
    check("c1_busy",     128'(busy),     128'd1);
    check("c1_in_ready", 128'(in_ready), 128'd0);
    wait_idle();

    // Case 2: g - s cancels exactly, every lane +0.
    send(Y2, G2, D2, 1'b1, 1'b0, a1);
    wait_idle();

    // Case 3: zero products keep their sign.
    send(Y3, G3, D3, 1'b1, 1'b0, a1);
    wait_idle();

    // Case 4: backpressure in DONE.
    out_ready = 1'b0;
    send(Y1, G1, D1, 1'b1, 1'b0, a1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    check("c4_out_valid_rise", 128'(seen), 128'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("c4_dx_hold",     dx,              D1);
      check("c4_in_ready_lo", 128'(in_ready),  128'd0);
      check("c4_valid_hold",  128'(out_valid), 128'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("c4_out_valid_drop", 128'(out_valid), 128'd0);
    check("c4_in_ready_back",  128'(in_ready),  128'd1);
    wait_idle();

    // Case 5: reset in the fourth cycle after accept aborts with no output.
    send(Y1, G1, D1, 1'b0, 1'b0, a1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("c5_in_ready", 128'(in_ready),  128'd1);
    check("c5_busy",     128'(busy),      128'd0);
    check("c5_valid",    128'(out_valid), 128'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("c5_no_output", 128'(seen), 128'd0);
    @(posedge clk); #1;
    send(Y2, G2, D2, 1'b1, 1'b0, a1);
    wait_idle();

    // Case 6: back-to-back with in_valid held, then a NaN gradient.
    send(Y1, G1, D1, 1'b1, 1'b1, a1);
    send(Y2, G2, D2, 1'b1, 1'b0, a2);
    check("c6_b2b_accept", 128'(a2), 128'(hs_edge + 1));
    wait_idle();
    send(Y1, GN, DN, 1'b1, 1'b0, a1);
    wait_idle();

    check("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
